mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Owner encoding for the granted requester.
  typedef enum logic [1:0] {
    OWN_IC = 2'd0,
    OWN_DC = 2'd1,
    OWN_SB = 2'd2
  } owner_t;

  localparam int DEF_MEM_LATENCY  = 5;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority pick between icache, dcache and store buffer.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
  input  logic   sb_req,
  input  logic   sb_full,
  input  logic   starve,
  output logic   valid,
  output owner_t owner
);

  // Starved icache first, then a full store buffer, then dcache, sb, ic.
  always_comb begin
    valid = ic_req | dc_req | sb_req;
    owner = OWN_IC;
    if (ic_req && starve) begin
      owner = OWN_IC;
    end else if (sb_req && sb_full) begin
      owner = OWN_SB;
    end else if (dc_req) begin
      owner = OWN_DC;
    end else if (sb_req) begin
      owner = OWN_SB;
    end else begin
      owner = OWN_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter for icache/dcache refills and store drains.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ic_req,
  input  logic [31:0]  ic_addr,
  output logic         ic_done,
  output logic [127:0] ic_rdata,
  input  logic         dc_req,
  input  logic [31:0]  dc_addr,
  output logic         dc_done,
  output logic [127:0] dc_rdata,
  input  logic         sb_req,
  input  logic [31:0]  sb_addr,
  input  logic [31:0]  sb_wdata,
  input  logic         sb_full,
  output logic         sb_done,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [127:0] mem_rdata,
  output logic         busy
);

  // Counter value at grant: counts down to 0 in the last BUSY cycle.
  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_reg, state_next;
  owner_t      owner_reg, owner_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [3:0]  starve_reg, starve_next;

  logic   pick_valid;
  owner_t pick_owner;
  logic   in_busy;
  logic   first_cyc;
  logic   last_cyc;

  mem_arb_pick u_pick (
    .ic_req  (ic_req),
    .dc_req  (dc_req),
    .sb_req  (sb_req),
    .sb_full (sb_full),
    .starve  (starve_reg == STARVE_MAX),
    .valid   (pick_valid),
    .owner   (pick_owner)
  );

  // State and latched-transaction registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= OWN_IC;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      cnt_reg    <= '0;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      cnt_reg    <= cnt_next;
      starve_reg <= starve_next;
    end
  end

  // Next-state logic: grant in IDLE, count down the memory latency in BUSY.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    cnt_next    = cnt_reg;
    starve_next = starve_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next = ST_BUSY;
          owner_next = pick_owner;
          cnt_next   = LAT_LOAD;
          case (pick_owner)
            OWN_IC: begin
              addr_next   = ic_addr;
              wdata_next  = '0;
              starve_next = '0;
            end
            OWN_DC: begin
              addr_next  = dc_addr;
              wdata_next = '0;
            end
            default: begin
              addr_next  = sb_addr;
              wdata_next = sb_wdata;
            end
          endcase
          // Non-icache grant while icache waits: bump the saturating starve count.
          if (pick_owner != OWN_IC && ic_req && starve_reg != STARVE_MAX) begin
            starve_next = starve_reg + 4'd1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted so an abandoned
  // transaction never shows a done pulse.
  assign in_busy   = rst && (state_reg == ST_BUSY);
  assign first_cyc = in_busy && (cnt_reg == LAT_LOAD);
  assign last_cyc  = in_busy && (cnt_reg == 4'd0);

  assign busy      = in_busy;
  assign mem_req   = first_cyc;
  assign mem_we    = first_cyc && (owner_reg == OWN_SB);
  assign mem_addr  = first_cyc ? addr_reg : 32'd0;
  assign mem_wdata = first_cyc ? wdata_reg : 32'd0;

  assign ic_done  = last_cyc && (owner_reg == OWN_IC);
  assign dc_done  = last_cyc && (owner_reg == OWN_DC);
  assign sb_done  = last_cyc && (owner_reg == OWN_SB);
  assign ic_rdata = ic_done ? mem_rdata : 128'd0;
  assign dc_rdata = dc_done ? mem_rdata : 128'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected commands queued at stimulus time,
// checked when the DUT issues mem_req and done pulses.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req, dc_req, sb_req, sb_full;
  logic [31:0]  ic_addr, dc_addr, sb_addr, sb_wdata;
  logic         ic_done, dc_done, sb_done;
  logic [127:0] ic_rdata, dc_rdata;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic [127:0] mem_rdata;
  logic         busy;

  typedef struct {
    logic [1:0]  owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          req_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  logic pend_valid = 1'b0;
  int   pend_done  = 0;
  logic [127:0] exp_line = '0;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_done(dc_done), .dc_rdata(dc_rdata),
    .sb_req(sb_req), .sb_addr(sb_addr), .sb_wdata(sb_wdata), .sb_full(sb_full),
    .sb_done(sb_done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [1:0] o, input logic we, input logic [31:0] a,
                          input logic [31:0] w, input int c);
    exp_t e;
    e.owner = o; e.we = we; e.addr = a; e.wdata = w; e.req_cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor and memory model: sample away from the active edge.
  always @(negedge clk) begin
    logic [2:0] dn;
    logic [2:0] dn_exp;
    logic       exp_busy;
    dn = {ic_done, dc_done, sb_done};
    if (!rst) begin
      check_eq("rst_outs", {dn, mem_req, mem_we, busy, mem_addr, mem_wdata}, '0);
      pend_valid = 1'b0;
    end else begin
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_mem_req", 1'b1, 1'b0);
        end else begin
          pend = exp_q.pop_front();
          check_eq("req_cyc", 128'(cyc), 128'(pend.req_cyc));
          check_eq("mem_we", mem_we, pend.we);
          check_eq("mem_addr", mem_addr, pend.addr);
          check_eq("mem_wdata", mem_wdata, pend.wdata);
          pend_valid = 1'b1;
          pend_done  = cyc + LAT - 1;
          exp_line   = {mem_addr, ~mem_addr, mem_addr ^ 32'hA5A5_A5A5, 32'(cyc)};
          mem_rdata  = exp_line;
        end
      end
      exp_busy = pend_valid;
      check_eq("busy", busy, exp_busy);
      if (dn != 3'b000) begin
        if (!pend_valid) begin
          check_eq("unexp_done", dn, 3'b000);
        end else begin
          case (pend.owner)
            OWN_IC:  dn_exp = 3'b100;
            OWN_DC:  dn_exp = 3'b010;
            default: dn_exp = 3'b001;
          endcase
          check_eq("done_cyc", 128'(cyc), 128'(pend_done));
          check_eq("done_owner", dn, dn_exp);
          check_eq("ic_rdata", ic_rdata, (pend.owner == OWN_IC) ? exp_line : 128'd0);
          check_eq("dc_rdata", dc_rdata, (pend.owner == OWN_DC) ? exp_line : 128'd0);
          pend_valid = 1'b0;
        end
      end else begin
        check_eq("idle_rdata", {ic_rdata, dc_rdata}, '0);
        if (pend_valid && cyc >= pend_done) begin
          check_eq("missing_done", 1'b0, 1'b1);
          pend_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b0;
    ic_req = 0; dc_req = 0; sb_req = 0; sb_full = 0;
    ic_addr = 0; dc_addr = 0; sb_addr = 0; sb_wdata = 0;
    mem_rdata = '0;
    run(3);
    rst = 1'b1;
    run(2);

    // Single dcache refill.
    t = cyc;
    dc_req = 1; dc_addr = 32'h0000_1040;
    push_exp(OWN_DC, 1'b0, 32'h0000_1040, 32'd0, t + 1);
    $display("txn dc single at cyc %0d", t);
    run(LAT); dc_req = 0;
    run(2);

    // All three requesting: dc, then sb, then ic.
    t = cyc;
    ic_req = 1; ic_addr = 32'h0000_2000;
    dc_req = 1; dc_addr = 32'h0000_3040;
    sb_req = 1; sb_addr = 32'h0000_4004; sb_wdata = 32'h1234_5678;
    push_exp(OWN_DC, 1'b0, 32'h0000_3040, 32'd0, t + 1);
    push_exp(OWN_SB, 1'b1, 32'h0000_4004, 32'h1234_5678, t + 7);
    push_exp(OWN_IC, 1'b0, 32'h0000_2000, 32'd0, t + 13);
    $display("txn all three at cyc %0d", t);
    run(LAT); dc_req = 0;
    run(6);   sb_req = 0;
    run(6);   ic_req = 0;
    run(2);

    // Starvation: four dc grants, forced ic, then dc wins again (count cleared).
    t = cyc;
    ic_req = 1; ic_addr = 32'h0000_5000;
    dc_req = 1; dc_addr = 32'h0000_6080;
    for (int i = 0; i < 4; i++) push_exp(OWN_DC, 1'b0, 32'h0000_6080, 32'd0, t + 1 + 6 * i);
    push_exp(OWN_IC, 1'b0, 32'h0000_5000, 32'd0, t + 25);
    push_exp(OWN_DC, 1'b0, 32'h0000_6080, 32'd0, t + 31);
    $display("txn starve at cyc %0d", t);
    run(35); ic_req = 0; dc_req = 0;
    run(2);

    // Full store buffer beats dcache.
    t = cyc;
    sb_full = 1; sb_req = 1; sb_addr = 32'h0000_7008; sb_wdata = 32'hDEAD_BEEF;
    dc_req = 1; dc_addr = 32'h0000_80C0;
    push_exp(OWN_SB, 1'b1, 32'h0000_7008, 32'hDEAD_BEEF, t + 1);
    push_exp(OWN_DC, 1'b0, 32'h0000_80C0, 32'd0, t + 7);
    $display("txn sb_full at cyc %0d", t);
    run(LAT); sb_req = 0; sb_full = 0;
    run(6);   dc_req = 0;
    run(2);

    // One-cycle dc pulse still completes, no second grant.
    t = cyc;
    dc_req = 1; dc_addr = 32'h0000_9100;
    push_exp(OWN_DC, 1'b0, 32'h0000_9100, 32'd0, t + 1);
    $display("txn dc pulse at cyc %0d", t);
    run(1); dc_req = 0;
    run(9);

    // Reset mid-transaction abandons it; fresh ic request afterwards.
    t = cyc;
    dc_req = 1; dc_addr = 32'h0000_A140;
    push_exp(OWN_DC, 1'b0, 32'h0000_A140, 32'd0, t + 1);
    $display("txn reset abort at cyc %0d", t);
    run(3); rst = 0; dc_req = 0;
    run(1); rst = 1;
    check_eq("busy_after_rst", busy, 1'b0);
    run(2);
    ic_req = 1; ic_addr = 32'h0000_B000;
    push_exp(OWN_IC, 1'b0, 32'h0000_B000, 32'd0, t + 7);
    run(LAT); ic_req = 0;
    run(4);

    check_eq("queue_empty", 128'(exp_q.size()), 128'd0);
    check_eq("no_pending", pend_valid, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
